sb_repair_msg_handler: RTL and testbench

Sideband-facing counterpart of the MBTRAIN REPAIR substate logic. Accepts 4-bit message codes and 3-bit data-lane encodings from the REPAIR tx/rx pair and turns them into 24-bit sideband packets for the sideband transmitter. Decodes incoming 24-bit sideband packets back into message code and lane encoding, with a one-cycle valid pulse. Drives the `busy` level that REPAIR edge-detects to sequence its messages.

---
 rtl/sb_repair_msg_handler_if.sv | 37 +++
 rtl/sb_repair_msg_handler.sv | 142 ++++++++++++++
 tb/tb_sb_repair_msg_handler.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_repair_msg_handler_if.sv
// Sideband repair message handler bus.
// Groups the REPAIR request side, the sideband transmitter handshake, the
// sideband receive path and the status pulses of sb_repair_msg_handler.
//   master : drives requests/ready/rx packets, observes results (REPAIR + sideband side)
//   slave  : the handler itself
interface sb_repair_msg_handler_if;
    logic        i_valid;
    logic [3:0]  i_sideband_message;
    logic [2:0]  i_sideband_data_lanes_encoding;
    logic        o_busy;
    logic [23:0] o_sb_tx_pkt;
    logic        o_sb_tx_valid;
    logic        i_sb_tx_ready;
    logic [23:0] i_sb_rx_pkt;
    logic        i_sb_rx_valid;
    logic [3:0]  o_rx_sideband_message;
    logic [2:0]  o_rx_data_lanes_encoding;
    logic        o_rx_msg_valid;
    logic        o_err;
    logic        o_timeout;

    modport master (
        output i_valid, i_sideband_message, i_sideband_data_lanes_encoding,
        output i_sb_tx_ready, i_sb_rx_pkt, i_sb_rx_valid,
        input  o_busy, o_sb_tx_pkt, o_sb_tx_valid,
        input  o_rx_sideband_message, o_rx_data_lanes_encoding, o_rx_msg_valid,
        input  o_err, o_timeout
    );

    modport slave (
        input  i_valid, i_sideband_message, i_sideband_data_lanes_encoding,
        input  i_sb_tx_ready, i_sb_rx_pkt, i_sb_rx_valid,
        output o_busy, o_sb_tx_pkt, o_sb_tx_valid,
        output o_rx_sideband_message, o_rx_data_lanes_encoding, o_rx_msg_valid,
        output o_err, o_timeout
    );
endinterface

// File: rtl/sb_repair_msg_handler.sv
// MBTRAIN REPAIR sideband message handler.
// Encodes REPAIR message code + lane encoding into 24-bit sideband packets
// ({4'hB, code, 13'b0, lanes}), holds them until the sideband transmitter
// accepts (or a timeout expires), and decodes received packets back into
// code + lane encoding with a one-cycle valid pulse.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   i_en   : block enable; low returns everything to reset state next edge
//   bus    : sb_repair_msg_handler_if.slave (request, tx handshake, rx, status)
module sb_repair_msg_handler #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_en,
    sb_repair_msg_handler_if.slave  bus
);

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    localparam logic [3:0]  PKT_HDR   = 4'hB;
    localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [23:0] pkt_q, pkt_d;
    logic        err_q, err_d;
    logic        timeout_q, timeout_d;
    logic [3:0]  rx_msg_q, rx_msg_d;
    logic [2:0]  rx_lanes_q, rx_lanes_d;
    logic        rx_vld_q, rx_vld_d;

    logic        tx_err;
    logic        rx_err;
    logic        rx_legal;

    function automatic logic code_legal(input logic [3:0] code);
        return (code >= 4'd1) && (code <= 4'd6);
    endfunction

    assign rx_legal = (bus.i_sb_rx_pkt[23:20] == PKT_HDR)
                   && code_legal(bus.i_sb_rx_pkt[19:16])
                   && (bus.i_sb_rx_pkt[15:3] == '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pkt_d      = pkt_q;
        timeout_d  = 1'b0;
        rx_msg_d   = rx_msg_q;
        rx_lanes_d = rx_lanes_q;
        rx_vld_d   = 1'b0;
        tx_err     = 1'b0;
        rx_err     = 1'b0;

        if (!i_en) begin
            state_d    = IDLE;
            cnt_d      = '0;
            pkt_d      = '0;
            rx_msg_d   = '0;
            rx_lanes_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.i_valid) begin
                        if (code_legal(bus.i_sideband_message)) begin
                            state_d = SEND;
                            cnt_d   = '0;
                            pkt_d   = {PKT_HDR, bus.i_sideband_message, 13'd0,
                                       bus.i_sideband_data_lanes_encoding};
                        end else begin
                            tx_err = 1'b1;
                        end
                    end
                end
                SEND: begin
                    // Ready wins over the limit when both land in the same cycle.
                    if (bus.i_sb_tx_ready) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LIMIT) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (bus.i_sb_rx_valid) begin
                if (rx_legal) begin
                    rx_msg_d   = bus.i_sb_rx_pkt[19:16];
                    rx_lanes_d = bus.i_sb_rx_pkt[2:0];
                    rx_vld_d   = 1'b1;
                end else begin
                    rx_err = 1'b1;
                end
            end
        end

        // A tx and an rx error in the same cycle merge into one pulse.
        err_d = tx_err | rx_err;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pkt_q      <= '0;
            err_q      <= 1'b0;
            timeout_q  <= 1'b0;
            rx_msg_q   <= '0;
            rx_lanes_q <= '0;
            rx_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pkt_q      <= pkt_d;
            err_q      <= err_d;
            timeout_q  <= timeout_d;
            rx_msg_q   <= rx_msg_d;
            rx_lanes_q <= rx_lanes_d;
            rx_vld_q   <= rx_vld_d;
        end
    end

    assign bus.o_busy                   = (state_q == SEND);
    assign bus.o_sb_tx_valid            = (state_q == SEND);
    assign bus.o_sb_tx_pkt              = pkt_q;
    assign bus.o_err                    = err_q;
    assign bus.o_timeout                = timeout_q;
    assign bus.o_rx_sideband_message    = rx_msg_q;
    assign bus.o_rx_data_lanes_encoding = rx_lanes_q;
    assign bus.o_rx_msg_valid           = rx_vld_q;

endmodule

// File: tb/tb_sb_repair_msg_handler.sv
// Scoreboard bench for sb_repair_msg_handler (TIMEOUT_CYCLES = 8).
// Stimulus tasks push expected transmit transactions, decoded messages and
// error-pulse cycles; a negedge monitor pops and compares them against what
// the handler presents.
module tb_sb_repair_msg_handler;

    localparam int T = 8;

    logic clk;
    logic rst_n;
    logic i_en;
    int   cyc;

    sb_repair_msg_handler_if bus ();

    sb_repair_msg_handler #(.TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (i_en),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] pkt;
        int          len;
        bit          to;
    } tx_exp_t;

    typedef struct {
        int msg;
        int lanes;
        int at;
    } rx_exp_t;

    tx_exp_t tx_q[$];
    rx_exp_t rx_q[$];
    bit      err_exp[int];

    int n_checks;
    int n_errors;
    bit mon_en;
    int tx_run;
    int held_msg;
    int held_lanes;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model, written from the packet rules with plain arithmetic.
    function automatic bit model_code_legal(input int code);
        return (code >= 1) && (code <= 6);
    endfunction

    function automatic logic [23:0] model_pkt(input int code, input int lanes);
        return 24'(11 * 1048576 + code * 65536 + lanes);
    endfunction

    task automatic send(input int code, input int lanes, input int d, input bit poke);
        int n;
        bus.i_valid = 1'b1;
        bus.i_sideband_message = 4'(code);
        bus.i_sideband_data_lanes_encoding = 3'(lanes);
        @(posedge clk); #1;
        n = cyc;
        bus.i_valid = 1'b0;
        if (!model_code_legal(code)) begin
            err_exp[n] = 1'b1;
            return;
        end
        tx_q.push_back('{pkt: model_pkt(code, lanes),
                         len: (d <= T) ? d + 1 : T + 1,
                         to:  (d > T)});
        if (d <= T) begin
            for (int k = 0; k < d; k++) begin
                if (poke && k == 0) begin
                    // a request during busy must be ignored silently
                    bus.i_valid = 1'b1;
                    bus.i_sideband_message = 4'($urandom_range(0, 15));
                end
                @(posedge clk); #1;
                bus.i_valid = 1'b0;
            end
            bus.i_sb_tx_ready = 1'b1;
            @(posedge clk); #1;
            bus.i_sb_tx_ready = 1'b0;
        end else begin
            repeat (T + 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic rx_send(input logic [23:0] p);
        int n;
        int pi;
        pi = int'(p);
        bus.i_sb_rx_pkt = p;
        bus.i_sb_rx_valid = 1'b1;
        @(posedge clk); #1;
        n = cyc;
        bus.i_sb_rx_valid = 1'b0;
        if ((pi / 1048576) == 11 && model_code_legal((pi / 65536) % 16) && ((pi / 8) % 8192) == 0)
            rx_q.push_back('{msg: (pi / 65536) % 16, lanes: pi % 8, at: n});
        else
            err_exp[n] = 1'b1;
    endtask

    // Start a send, then kill it two cycles in with either i_en or rst_n.
    task automatic abort_send(input bit use_rst);
        bus.i_valid = 1'b1;
        bus.i_sideband_message = 4'd5;
        bus.i_sideband_data_lanes_encoding = 3'd6;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        tx_q.push_back('{pkt: model_pkt(5, 6), len: 3, to: 1'b0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (use_rst) rst_n = 1'b0; else i_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        i_en = 1'b1;
        @(negedge clk);
        chk(use_rst ? "rst_busy" : "en_busy", bus.o_busy, 0);
        chk(use_rst ? "rst_pkt" : "en_pkt", bus.o_sb_tx_pkt, 0);
        chk(use_rst ? "rst_rx_fields" : "en_rx_fields",
            {bus.o_rx_sideband_message, bus.o_rx_data_lanes_encoding}, 0);
        chk(use_rst ? "rst_timeout" : "en_timeout", bus.o_timeout, 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.o_sb_tx_valid) begin
                chk("busy_vs_valid", bus.o_busy, 1);
                chk("timeout_during_send", bus.o_timeout, 0);
                if (tx_q.size() == 0) chk("tx_valid_unexpected", bus.o_sb_tx_valid, 0);
                else begin
                    chk("tx_pkt", bus.o_sb_tx_pkt, tx_q[0].pkt);
                    tx_run++;
                end
            end else begin
                chk("busy_idle", bus.o_busy, 0);
                if (tx_run > 0) begin
                    chk("busy_len", tx_run, tx_q[0].len);
                    chk("timeout_pulse", bus.o_timeout, tx_q[0].to);
                    void'(tx_q.pop_front());
                    tx_run = 0;
                end else if (bus.o_timeout) begin
                    chk("timeout_unexpected", bus.o_timeout, 0);
                end
            end

            if (bus.o_rx_msg_valid) begin
                if (rx_q.size() == 0) chk("rx_valid_unexpected", bus.o_rx_msg_valid, 0);
                else begin
                    chk("rx_msg", bus.o_rx_sideband_message, rx_q[0].msg);
                    chk("rx_lanes", bus.o_rx_data_lanes_encoding, rx_q[0].lanes);
                    chk("rx_cycle", cyc, rx_q[0].at);
                    held_msg = rx_q[0].msg;
                    held_lanes = rx_q[0].lanes;
                    void'(rx_q.pop_front());
                end
            end else begin
                chk("rx_hold_msg", bus.o_rx_sideband_message, held_msg);
                chk("rx_hold_lanes", bus.o_rx_data_lanes_encoding, held_lanes);
            end

            if (err_exp.exists(cyc)) begin
                chk("err_pulse", bus.o_err, 1);
                err_exp.delete(cyc);
            end else begin
                chk("err_unexpected", bus.o_err, 0);
            end

            if (!rst_n || !i_en) begin
                held_msg = 0;
                held_lanes = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_en = 1'b0;
        tx_run = 0;
        held_msg = 0;
        held_lanes = 0;
        rst_n = 1'b0;
        i_en = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_sideband_message = '0;
        bus.i_sideband_data_lanes_encoding = '0;
        bus.i_sb_tx_ready = 1'b0;
        bus.i_sb_rx_pkt = '0;
        bus.i_sb_rx_valid = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tx", {bus.o_busy, bus.o_sb_tx_valid, bus.o_sb_tx_pkt}, 0);
        chk("reset_rx", {bus.o_rx_msg_valid, bus.o_rx_sideband_message, bus.o_rx_data_lanes_encoding}, 0);
        chk("reset_flags", {bus.o_err, bus.o_timeout}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // directed transmit cases
        send(3, 2, 0, 1'b0);      // 24'hB30002, busy 1 cycle
        send(5, 1, 5, 1'b1);      // ready after 5, ignored request during busy
        send(1, 0, T + 1, 1'b0);  // never ready -> timeout
        send(4, 4, 0, 1'b0);      // accepted after timeout
        send(2, 7, T, 1'b0);      // ready exactly at the limit -> no timeout
        send(0, 1, 0, 1'b0);      // illegal code
        send(9, 3, 0, 1'b0);      // illegal code

        // directed receive cases
        rx_send(24'hB60005);
        rx_send(24'hA60005);
        rx_send(24'hB00000);
        rx_send(24'hB60008);
        repeat (2) begin @(posedge clk); #1; end

        // randomized concurrent tx and rx traffic
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int c;
                    if ($urandom_range(0, 9) < 8) c = int'($urandom_range(1, 6));
                    else begin
                        c = int'($urandom_range(7, 16));
                        if (c == 16) c = 0;
                    end
                    send(c, int'($urandom_range(0, 7)), int'($urandom_range(0, 10)),
                         1'($urandom_range(0, 1)));
                end
            end
            begin
                for (int j = 0; j < 60; j++) begin
                    logic [23:0] p;
                    int kind;
                    int g;
                    p = model_pkt(int'($urandom_range(1, 6)), int'($urandom_range(0, 7)));
                    kind = int'($urandom_range(0, 4));
                    if (kind == 2) p[23:20] = p[23:20] ^ 4'($urandom_range(1, 15));
                    else if (kind == 3) p[19:16] = 4'($urandom_range(0, 15));
                    else if (kind == 4) p[3 + int'($urandom_range(0, 12))] = 1'b1;
                    rx_send(p);
                    g = int'($urandom_range(0, 3));
                    repeat (g) begin @(posedge clk); #1; end
                end
            end
        join

        // enable drop and reset in the middle of a send
        rx_send(24'hB40003);
        abort_send(1'b0);
        rx_send(24'hB10007);
        abort_send(1'b1);
        send(6, 1, 2, 1'b0);

        repeat (5) begin @(posedge clk); #1; end
        chk("tx_q_drained", tx_q.size(), 0);
        chk("rx_q_drained", rx_q.size(), 0);
        chk("err_drained", err_exp.num(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
